mem_bus_arbiter: RTL and testbench

//  Shares the single Avalon-style memory bus between the CPU instruction-fetch port and

---
 rtl/mem_bus_arbiter_if.sv | 51 +++++
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Fetch port, data port and shared memory bus signals of the
//               instruction/data bus arbiter, bundled with two views.
//               slave  - the arbiter (serves fetch/LSU, drives the bus)
//               master - the surrounding fetch unit, LSU and memory
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if;
  // Instruction-fetch port
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  // Data (load/store) port
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  // Shared memory bus
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;

  modport slave (
    input  i_address, i_read,
    output i_waitrequest, i_readdata,
    input  d_address, d_read, d_write, d_writedata, d_byteenable,
    output d_waitrequest, d_readdata,
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata
  );

  modport master (
    output i_address, i_read,
    input  i_waitrequest, i_readdata,
    output d_address, d_read, d_write, d_writedata, d_byteenable,
    input  d_waitrequest, d_readdata,
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Round-robin 2:1 arbiter sharing one Avalon-style memory bus
//               between the instruction-fetch and load/store ports. One
//               transfer outstanding at a time, fixed read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int READ_LATENCY = 1   // 0..3 cycles from read accept to data
) (
  input  logic              clk,
  input  logic              reset,   // asynchronous, active low
  mem_bus_arbiter_if.slave  bus
);

  localparam logic [2:0] C_S_IDLE   = 3'd0;
  localparam logic [2:0] C_S_BUS_I  = 3'd1;
  localparam logic [2:0] C_S_BUS_D  = 3'd2;
  localparam logic [2:0] C_S_WAIT_I = 3'd3;
  localparam logic [2:0] C_S_WAIT_D = 3'd4;

  localparam logic C_GRANT_I = 1'b0;
  localparam logic C_GRANT_D = 1'b1;

  // Zero-latency builds return data in the accept cycle and never use lat_cnt
  localparam logic       C_LAT0     = (READ_LATENCY == 0);
  localparam logic [1:0] C_LAT_LOAD = C_LAT0 ? 2'd0 : 2'(READ_LATENCY - 1);

  logic [2:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic w_d_req;
  assign w_d_req = bus.d_read | bus.d_write;

  // State register; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= C_S_IDLE;
      last_grant_q <= C_GRANT_D;
      lat_cnt_q    <= 2'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_cnt_q    <= lat_cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state: arbitration in IDLE, accept tracking in BUS_x, latency count in WAIT_x
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lat_cnt_d    = lat_cnt_q;
    rdata_d      = rdata_q;
    case (state_q)
      C_S_IDLE: begin
        // With both requesting, the port not served last time wins
        if (bus.i_read && (!w_d_req || last_grant_q == C_GRANT_D)) begin
          state_d      = C_S_BUS_I;
          last_grant_d = C_GRANT_I;
        end else if (w_d_req) begin
          state_d      = C_S_BUS_D;
          last_grant_d = C_GRANT_D;
        end
      end
      C_S_BUS_I: begin
        if (!bus.i_read) begin
          state_d = C_S_IDLE;
        end else if (!bus.m_waitrequest) begin
          if (C_LAT0) begin
            rdata_d = bus.m_readdata;
            state_d = C_S_IDLE;
          end else begin
            lat_cnt_d = C_LAT_LOAD;
            state_d   = C_S_WAIT_I;
          end
        end
      end
      C_S_BUS_D: begin
        if (!w_d_req) begin
          state_d = C_S_IDLE;
        end else if (!bus.m_waitrequest) begin
          if (bus.d_write) begin
            state_d = C_S_IDLE;
          end else if (C_LAT0) begin
            rdata_d = bus.m_readdata;
            state_d = C_S_IDLE;
          end else begin
            lat_cnt_d = C_LAT_LOAD;
            state_d   = C_S_WAIT_D;
          end
        end
      end
      C_S_WAIT_I, C_S_WAIT_D: begin
        if (lat_cnt_q == 2'd0) begin
          // A requester that let go after accept gets its data discarded
          if ((state_q == C_S_WAIT_I) ? bus.i_read : bus.d_read) begin
            rdata_d = bus.m_readdata;
          end
          state_d = C_S_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      default: state_d = C_S_IDLE;
    endcase
  end

  // Outputs: bus strobes mirror the granted port, completions release waitrequest
  always_comb begin
    bus.m_address     = 32'd0;
    bus.m_read        = 1'b0;
    bus.m_write       = 1'b0;
    bus.m_writedata   = 32'd0;
    bus.m_byteenable  = 4'd0;
    bus.i_waitrequest = 1'b1;
    bus.d_waitrequest = 1'b1;
    bus.i_readdata    = rdata_q;
    bus.d_readdata    = rdata_q;
    case (state_q)
      C_S_BUS_I: begin
        bus.m_address    = bus.i_address;
        bus.m_read       = bus.i_read;
        bus.m_byteenable = 4'hF;
        if (C_LAT0 && bus.i_read && !bus.m_waitrequest) begin
          bus.i_waitrequest = 1'b0;
          bus.i_readdata    = bus.m_readdata;
        end
      end
      C_S_BUS_D: begin
        bus.m_address    = bus.d_address;
        bus.m_write      = bus.d_write;
        bus.m_read       = bus.d_read & ~bus.d_write;
        bus.m_writedata  = bus.d_writedata;
        bus.m_byteenable = bus.d_byteenable;
        if (w_d_req && !bus.m_waitrequest && (bus.d_write || C_LAT0)) begin
          bus.d_waitrequest = 1'b0;
          if (!bus.d_write) bus.d_readdata = bus.m_readdata;
        end
      end
      C_S_WAIT_I: begin
        if (lat_cnt_q == 2'd0) begin
          bus.i_waitrequest = 1'b0;
          bus.i_readdata    = bus.m_readdata;
        end
      end
      C_S_WAIT_D: begin
        if (lat_cnt_q == 2'd0) begin
          bus.d_waitrequest = 1'b0;
          bus.d_readdata    = bus.m_readdata;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter: directed steps plus
//               randomized fetch/load/store traffic against a word-memory
//               reference model and round-robin fairness rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  localparam logic [31:0] BASE    = 32'hBFC00000;
  localparam int          TIMEOUT = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bm();
  mem_bus_arbiter_if bz();
  mem_bus_arbiter_if b3();

  mem_bus_arbiter #(.READ_LATENCY(1)) dut  (.clk(clk), .reset(rst_n), .bus(bm));
  mem_bus_arbiter #(.READ_LATENCY(0)) dut0 (.clk(clk), .reset(rst_n), .bus(bz));
  mem_bus_arbiter #(.READ_LATENCY(3)) dut3 (.clk(clk), .reset(rst_n), .bus(b3));

  function automatic logic [31:0] init_word(input int k);
    if (k == 0)  return 32'h3C08BFC0;
    if (k == 11) return 32'h00FF00FF;
    return {16'hC0DE, 8'(k), ~8'(k)};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Bus-side memory with one cycle of read latency (environment, not the model)
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
      bm.m_readdata <= 32'd0;
    end else begin
      if (bm.m_write && !bm.m_waitrequest)
        mem[bm.m_address[7:2]] <= merge(mem[bm.m_address[7:2]], bm.m_writedata, bm.m_byteenable);
      bm.m_readdata <= (bm.m_read && !bm.m_waitrequest) ? mem[bm.m_address[7:2]] : 32'h0BAD0BAD;
    end
  end

  // Reference state
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ref_mem [64];
  bit          i_act, d_act, d_wr;
  int          i_idx, d_idx, i_age, d_age, i_other, d_other;
  logic [31:0] d_data;
  logic [3:0]  d_be;
  bit          glog [$];   // completion order: 0 = fetch, 1 = data

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic init_model();
    for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
    i_act = 1'b0;
    d_act = 1'b0;
    glog.delete();
    bm.i_read = 1'b0;  bm.d_read = 1'b0;  bm.d_write = 1'b0;
    bm.m_waitrequest = 1'b0;
  endtask

  task automatic issue_i(input int idx);
    i_act = 1'b1;  i_idx = idx;  i_age = 0;  i_other = 0;
    bm.i_read    = 1'b1;
    bm.i_address = BASE + 32'(idx * 4);
  endtask

  task automatic issue_d(input bit wr, input int idx, input logic [31:0] data, input logic [3:0] be);
    d_act = 1'b1;  d_wr = wr;  d_idx = idx;  d_data = data;  d_be = be;  d_age = 0;  d_other = 0;
    bm.d_write      = wr;
    bm.d_read       = !wr;
    bm.d_address    = BASE + 32'(idx * 4);
    bm.d_writedata  = data;
    bm.d_byteenable = be;
  endtask

  // Check completions against the model; a port may be overtaken at most once
  task automatic observe();
    bit ic, dc;
    ic = i_act && (bm.i_waitrequest === 1'b0);
    dc = d_act && (bm.d_waitrequest === 1'b0);
    if (ic || dc) check1("single_owner", ic && dc, 1'b0);
    if (ic) begin
      check("i_readdata", bm.i_readdata, ref_mem[i_idx]);
      check1("i_fair", i_other <= 1, 1'b1);
      glog.push_back(1'b0);
      if (d_act && !dc) d_other++;
    end
    if (dc) begin
      if (d_wr) ref_mem[d_idx] = merge(ref_mem[d_idx], d_data, d_be);
      else      check("d_readdata", bm.d_readdata, ref_mem[d_idx]);
      check1("d_fair", d_other <= 1, 1'b1);
      glog.push_back(1'b1);
      if (i_act && !ic) i_other++;
    end
    if (ic) i_act = 1'b0;
    if (dc) d_act = 1'b0;
    if (i_act) i_age++;
    if (d_act) d_age++;
    assert (!(i_act && i_age >= TIMEOUT)) else begin
      n_tests++;  n_fail++;
      $error("FAIL i_timeout: observed %0d cycles required < %0d", i_age, TIMEOUT);
      i_act = 1'b0;
    end
    assert (!(d_act && d_age >= TIMEOUT)) else begin
      n_tests++;  n_fail++;
      $error("FAIL d_timeout: observed %0d cycles required < %0d", d_age, TIMEOUT);
      d_act = 1'b0;
    end
  endtask

  task automatic cyc();
    #1;
    observe();
    @(posedge clk);
    #1;
    if (!i_act) bm.i_read = 1'b0;
    if (!d_act) begin bm.d_read = 1'b0; bm.d_write = 1'b0; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((i_act || d_act) && n < TIMEOUT + 2) begin cyc(); n++; end
  endtask

  initial begin
    int n, acc, done;
    // Side instances start idle with a ready bus
    bz.i_address = BASE; bz.i_read = 1'b0; bz.d_address = '0; bz.d_read = 1'b0; bz.d_write = 1'b0;
    bz.d_writedata = '0; bz.d_byteenable = '0; bz.m_waitrequest = 1'b0; bz.m_readdata = '0;
    b3.i_address = BASE; b3.i_read = 1'b0; b3.d_address = '0; b3.d_read = 1'b0; b3.d_write = 1'b0;
    b3.d_writedata = '0; b3.d_byteenable = '0; b3.m_waitrequest = 1'b0; b3.m_readdata = '0;

    // Reset state, with requests asserted to show they are ignored
    bm.i_address = BASE + 32'h10;  bm.i_read = 1'b1;
    bm.d_address = BASE + 32'h20;  bm.d_write = 1'b1;  bm.d_read = 1'b0;
    bm.d_writedata = 32'h55AA55AA; bm.d_byteenable = 4'hF;  bm.m_waitrequest = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check1("rst_m_read", bm.m_read, 1'b0);
    check1("rst_m_write", bm.m_write, 1'b0);
    check("rst_m_address", bm.m_address, 32'd0);
    check("rst_m_writedata", bm.m_writedata, 32'd0);
    check("rst_m_byteenable", 32'(bm.m_byteenable), 32'd0);
    check1("rst_i_wait", bm.i_waitrequest, 1'b1);
    check1("rst_d_wait", bm.d_waitrequest, 1'b1);
    check("rst_i_readdata", bm.i_readdata, 32'd0);
    check("rst_d_readdata", bm.d_readdata, 32'd0);
    init_model();
    @(posedge clk); #2 rst_n = 1'b1;

    // Reset in the middle of a stalled store
    issue_d(1'b1, 5, 32'h12345678, 4'hF);
    bm.m_waitrequest = 1'b1;
    cyc();
    #1 check1("t1_m_write_before", bm.m_write, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check1("t1_m_write_reset", bm.m_write, 1'b0);
    check1("t1_d_wait_reset", bm.d_waitrequest, 1'b1);
    check("t1_m_address_reset", bm.m_address, 32'd0);
    init_model();
    @(posedge clk); #2 rst_n = 1'b1;

    // Single fetch, latency 1: IDLE cycle, one strobe cycle, data next cycle
    issue_i(0);
    #1;
    check1("t2_idle_m_read", bm.m_read, 1'b0);
    check1("t2_idle_i_wait", bm.i_waitrequest, 1'b1);
    cyc();
    #1;
    check1("t2_bus_m_read", bm.m_read, 1'b1);
    check("t2_bus_m_address", bm.m_address, BASE);
    check("t2_bus_m_be", 32'(bm.m_byteenable), 32'hF);
    check1("t2_bus_i_wait", bm.i_waitrequest, 1'b1);
    cyc();
    #1;
    check1("t2_wait_m_read", bm.m_read, 1'b0);
    check1("t2_done_i_wait", bm.i_waitrequest, 1'b0);
    check("t2_done_data", bm.i_readdata, 32'h3C08BFC0);
    cyc();
    #1 check("t2_data_hold", bm.i_readdata, 32'h3C08BFC0);

    // Simultaneous fetch and load after reset: fetch first
    rst_n = 1'b0;
    init_model();
    @(posedge clk); #2 rst_n = 1'b1;
    issue_i(1);
    issue_d(1'b0, 11, 32'd0, 4'hF);
    drain();
    check("t3_count", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check1("t3_first_fetch", glog[0], 1'b0);
      check1("t3_second_data", glog[1], 1'b1);
    end
    check("t3_load_data", bm.d_readdata, 32'h00FF00FF);

    // Partial store held through three stall cycles, then read back
    issue_d(1'b1, 12, 32'hDEADBEEF, 4'b0011);
    bm.m_waitrequest = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      check1("t4_stall_m_write", bm.m_write, 1'b1);
      check("t4_stall_m_address", bm.m_address, BASE + 32'h30);
      check("t4_stall_m_wdata", bm.m_writedata, 32'hDEADBEEF);
      check("t4_stall_m_be", 32'(bm.m_byteenable), 32'h3);
      check1("t4_stall_d_wait", bm.d_waitrequest, 1'b1);
      cyc();
    end
    bm.m_waitrequest = 1'b0;
    #1 check1("t4_accept_d_wait", bm.d_waitrequest, 1'b0);
    cyc();
    #1 check1("t4_after_d_wait", bm.d_waitrequest, 1'b1);
    issue_d(1'b0, 12, 32'd0, 4'hF);
    drain();
    check("t4_readback", bm.d_readdata, 32'hC0DEBEEF);

    // Continuous requests from both ports: completions must alternate
    glog.delete();
    n = 0;
    while (glog.size() < 20 && n < 400) begin
      if (!i_act) issue_i(int'($urandom_range(0, 15)));
      if (!d_act) issue_d(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
                          4'($urandom_range(1, 15)));
      bm.m_waitrequest = ($urandom_range(0, 3) == 0);
      cyc();
      n++;
    end
    check1("t5_enough", glog.size() >= 20, 1'b1);
    for (int k = 1; k < glog.size(); k++) check1("t5_alternate", glog[k] != glog[k-1], 1'b1);
    bm.m_waitrequest = 1'b0;
    drain();

    // Random traffic mix
    for (int c = 0; c < 300; c++) begin
      if (!i_act && $urandom_range(0, 99) < 40) issue_i(int'($urandom_range(0, 15)));
      if (!d_act && $urandom_range(0, 99) < 40)
        issue_d(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
                4'($urandom_range(1, 15)));
      bm.m_waitrequest = ($urandom_range(0, 99) < 30);
      cyc();
    end
    bm.m_waitrequest = 1'b0;
    drain();

    // Latency-0 build: data in the accept cycle, bus data tagged by cycle number
    acc = -1;  done = -1;
    bz.i_read = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bz.m_readdata = 32'hA0000000 + 32'(c);
      #1;
      if (acc < 0 && bz.m_read) acc = c;
      if (done < 0 && !bz.i_waitrequest) begin
        done = c;
        check("t6_l0_data", bz.i_readdata, 32'hA0000000 + 32'(acc));
      end
      @(posedge clk); #1;
      if (done >= 0) bz.i_read = 1'b0;
    end
    check("t6_l0_accept", 32'(acc), 32'd1);
    check("t6_l0_latency", 32'(done - acc), 32'd0);

    // Latency-3 build: data exactly three cycles after accept
    acc = -1;  done = -1;
    b3.i_read = 1'b1;
    for (int c = 0; c < 10; c++) begin
      b3.m_readdata = 32'hB0000000 + 32'(c);
      #1;
      if (acc < 0 && b3.m_read) acc = c;
      if (done < 0 && !b3.i_waitrequest) begin
        done = c;
        check("t6_l3_data", b3.i_readdata, 32'hB0000000 + 32'(acc + 3));
      end
      @(posedge clk); #1;
      if (done >= 0) b3.i_read = 1'b0;
    end
    check("t6_l3_accept", 32'(acc), 32'd1);
    check("t6_l3_latency", 32'(done - acc), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
